bus_transfer_sched: RTL and testbench

Sequencer for the shared 32-bit tri-state register bus. Accepts register-to-register move commands (source index, destination index), queues them, and drives one-hot output-enable / input-enable strobes to the register bank. It guarantees that at most one register drives the bus in any cycle and that the destination captures only after the bus has settled for one full cycle. It sits between the instruction control logic and the register bank, replacing ad-hoc enable decoding.

---
 rtl/bus_transfer_sched.sv | 134 +++++++++++++
 tb/tb_bus_transfer_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sched.sv
// Register-bus transfer sequencer: queues src->dst move commands and drives
// registered one-hot output/input enables so exactly one register drives the bus.
module bus_transfer_sched #(
    parameter int NREGS  = 8,
    parameter int AW     = 5,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_src,
    input  logic [AW-1:0]    cmd_dst,
    input  logic             pause,
    output logic [NREGS-1:0] oe,
    output logic [NREGS-1:0] ie,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] NREGS_V = (AW+1)'(NREGS);
    localparam logic [PW:0] QDEPTH_V = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state;
    logic [2*AW-1:0] fifo_mem [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [AW-1:0]   src_r;
    logic [AW-1:0]   dst_r;

    logic            full;
    logic            empty;
    logic            accept;
    logic            bad;
    logic            push;
    logic            pop;
    logic [AW-1:0]   head_src;
    logic [AW-1:0]   head_dst;

    function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[i] = (idx == AW'(i));
        end
        return v;
    endfunction

    function automatic logic in_range(input logic [AW-1:0] idx);
        return ({1'b0, idx} < NREGS_V);
    endfunction

    assign full      = (count == QDEPTH_V);
    assign empty     = (count == '0);
    assign cmd_ready = !reset && !full;
    assign accept    = cmd_valid && cmd_ready;
    assign bad       = !(in_range(cmd_src) && in_range(cmd_dst));
    assign push      = accept && !bad;
    // A new transfer may start from IDLE or straight out of LATCH.
    assign pop       = (state != DRIVE) && !empty && !pause;
    assign {head_src, head_dst} = fifo_mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_src, cmd_dst};
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            src_r <= head_src;
            dst_r <= head_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            oe    <= '0;
            ie    <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= (state == LATCH);
            err  <= accept && bad;
            case (state)
                IDLE, LATCH: begin
                    if (pop) begin
                        state <= DRIVE;
                        oe    <= onehot(head_src);
                        ie    <= '0;
                    end else begin
                        state <= IDLE;
                        oe    <= '0;
                        ie    <= '0;
                    end
                end
                DRIVE: begin
                    state <= LATCH;
                    oe    <= onehot(src_r);
                    ie    <= onehot(dst_r);
                end
                default: begin
                    state <= IDLE;
                    oe    <= '0;
                    ie    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_transfer_sched.sv
// Bench for bus_transfer_sched: queue/phase model plus a register bank driven by the DUT enables.
module tb_bus_transfer_sched;
    localparam int NREGS  = 8;
    localparam int AW     = 5;
    localparam int QDEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_src;
    logic [AW-1:0]    cmd_dst;
    logic             pause;
    logic [NREGS-1:0] oe;
    logic [NREGS-1:0] ie;
    logic             busy;
    logic             done;
    logic             err;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_transfer_sched #(.NREGS(NREGS), .AW(AW), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .pause(pause),
        .oe(oe), .ie(ie), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 2) ? 32'hDEAD_BEEF : 32'(i) * 32'h1111_1111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register bank on the tri-state bus, driven by the DUT strobes.
    logic [31:0] regs [NREGS];

    function automatic logic [31:0] bus_value();
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < NREGS; i++) if (oe[i]) b = b | regs[i];
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= init_val(i);
        end else begin
            for (int d = 0; d < NREGS; d++) if (ie[d]) regs[d] <= bus_value();
        end
    end

    // Transaction-level model: a command queue and the transfer in flight.
    int               qs[$];
    int               qd[$];
    int               phase = 0;
    int               cur_s = 0;
    int               cur_d = 0;
    logic [NREGS-1:0] m_oe;
    logic [NREGS-1:0] m_ie;
    logic             m_done;
    logic             m_err;
    logic             m_busy;
    logic             mvalid = 1'b0;
    logic [31:0]      mregs [NREGS];
    bit               m_acc;
    bit               m_bad;
    logic [NREGS-1:0] one = NREGS'(1);

    initial forever begin
        @(posedge clk);
        if (reset) begin
            qs.delete();
            qd.delete();
            phase  = 0;
            m_done = 1'b0;
            m_err  = 1'b0;
            for (int i = 0; i < NREGS; i++) mregs[i] = init_val(i);
            mvalid = 1'b1;
        end else begin
            m_acc  = cmd_valid && (qs.size() < QDEPTH);
            m_bad  = (cmd_src >= NREGS) || (cmd_dst >= NREGS);
            m_err  = m_acc && m_bad;
            m_done = (phase == 2);
            if (phase == 2) mregs[cur_d] = mregs[cur_s];
            if (phase == 1) begin
                phase = 2;
            end else if (qs.size() != 0 && !pause) begin
                cur_s = qs.pop_front();
                cur_d = qd.pop_front();
                phase = 1;
            end else begin
                phase = 0;
            end
            if (m_acc && !m_bad) begin
                qs.push_back(int'(cmd_src));
                qd.push_back(int'(cmd_dst));
            end
        end
        m_oe   = (phase != 0) ? (one << cur_s) : '0;
        m_ie   = (phase == 2) ? (one << cur_d) : '0;
        m_busy = (phase != 0) || (qs.size() != 0);
    end

    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            check("oe", 32'(oe), 32'(m_oe));
            check("ie", 32'(ie), 32'(m_ie));
            check("done", 32'(done), 32'(m_done));
            check("err", 32'(err), 32'(m_err));
            check("busy", 32'(busy), 32'(m_busy));
            check("cmd_ready", 32'(cmd_ready), 32'(!reset && (qs.size() < QDEPTH)));
            check("oe_popcount_le1", 32'($countones(oe) <= 1), 32'(1));
            check("ie_popcount_le1", 32'($countones(ie) <= 1), 32'(1));
            check("ie_implies_oe", 32'((ie == '0) || (oe != '0)), 32'(1));
            for (int i = 0; i < NREGS; i++) check("regbank", regs[i], mregs[i]);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    int ndone;
    int s2 [4] = '{1, 0, 3, 7};
    int d2 [4] = '{0, 3, 7, 1};

    initial begin
        reset = 1'b1; cmd_valid = 1'b1; cmd_src = 5'd1; cmd_dst = 5'd2; pause = 1'b0;
        cyc(); cyc();
        check("ready_in_reset", 32'(cmd_ready), 32'(0));
        check("busy_in_reset", 32'(busy), 32'(0));
        check("oe_in_reset", 32'(oe), 32'(0));
        reset = 1'b0; cmd_valid = 1'b0;
        cyc();
        check("ready_after_reset", 32'(cmd_ready), 32'(1));
        check("busy_after_reset", 32'(busy), 32'(0));

        // single move 2 -> 5
        cmd_valid = 1'b1; cmd_src = 5'd2; cmd_dst = 5'd5;
        cyc(); cmd_valid = 1'b0;
        check("t1_oe_e0", 32'(oe), 32'h00);
        check("t1_busy_e0", 32'(busy), 32'(1));
        cyc();
        check("t1_oe_e1", 32'(oe), 32'h04);
        check("t1_ie_e1", 32'(ie), 32'h00);
        cyc();
        check("t1_oe_e2", 32'(oe), 32'h04);
        check("t1_ie_e2", 32'(ie), 32'h20);
        cyc();
        check("t1_oe_e3", 32'(oe), 32'h00);
        check("t1_done_e3", 32'(done), 32'(1));
        check("t1_reg5", regs[5], 32'hDEAD_BEEF);
        cyc();
        check("t1_done_after", 32'(done), 32'(0));
        check("t1_busy_after", 32'(busy), 32'(0));

        // four queued commands under pause, then released
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_src = AW'(s2[k]); cmd_dst = AW'(d2[k]);
            cyc();
            check("t2_ready", 32'(cmd_ready), 32'(k < 3));
        end
        cmd_src = 5'd2; cmd_dst = 5'd2;
        cyc();
        check("t2_ready_full", 32'(cmd_ready), 32'(0));
        check("t2_oe_paused", 32'(oe), 32'h00);
        cmd_valid = 1'b0; pause = 1'b0;
        cyc();
        check("t2_first_oe", 32'(oe), 32'h02);
        check("t2_ready_after_pop", 32'(cmd_ready), 32'(1));
        ndone = 0;
        repeat (10) begin
            cyc();
            if (done) ndone++;
        end
        check("t2_done_count", 32'(ndone), 32'(4));
        check("t2_reg7", regs[7], 32'h1111_1111);
        check("t2_reg3", regs[3], 32'h1111_1111);
        check("t2_busy_end", 32'(busy), 32'(0));

        // out-of-range indices
        cmd_valid = 1'b1; cmd_src = 5'd9; cmd_dst = 5'd1;
        cyc(); cmd_valid = 1'b0;
        check("t3_err_src", 32'(err), 32'(1));
        check("t3_busy_src", 32'(busy), 32'(0));
        cyc();
        check("t3_err_clear", 32'(err), 32'(0));
        check("t3_oe_zero", 32'(oe), 32'h00);
        cmd_valid = 1'b1; cmd_src = 5'd1; cmd_dst = 5'd8;
        cyc(); cmd_valid = 1'b0;
        check("t3_err_dst", 32'(err), 32'(1));
        cyc();
        check("t3_busy_dst", 32'(busy), 32'(0));

        // pause with two queued commands
        pause = 1'b1;
        cmd_valid = 1'b1; cmd_src = 5'd2; cmd_dst = 5'd6; cyc();
        cmd_src = 5'd6; cmd_dst = 5'd4; cyc();
        cmd_valid = 1'b0;
        repeat (5) begin
            cyc();
            check("t4_oe_paused", 32'(oe), 32'h00);
            check("t4_busy_paused", 32'(busy), 32'(1));
        end
        pause = 1'b0;
        cyc();
        check("t4_oe_release", 32'(oe), 32'h04);
        repeat (6) cyc();
        check("t4_reg4", regs[4], 32'hDEAD_BEEF);
        check("t4_busy_end", 32'(busy), 32'(0));

        // reset during LATCH with a 3-deep backlog
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_src = AW'(k); cmd_dst = AW'(k + 1);
            cyc();
        end
        cmd_valid = 1'b0; pause = 1'b0;
        cyc();
        check("t5_oe_drive", 32'(oe), 32'h01);
        cyc();
        check("t5_ie_latch", 32'(ie), 32'h02);
        reset = 1'b1; cmd_valid = 1'b1; cmd_src = 5'd5; cmd_dst = 5'd6;
        cyc();
        check("t5_oe_reset", 32'(oe), 32'h00);
        check("t5_ie_reset", 32'(ie), 32'h00);
        check("t5_busy_reset", 32'(busy), 32'(0));
        check("t5_done_reset", 32'(done), 32'(0));
        reset = 1'b0; cmd_valid = 1'b0;
        repeat (6) begin
            cyc();
            check("t5_no_stale_oe", 32'(oe), 32'h00);
            check("t5_no_stale_done", 32'(done), 32'(0));
        end
        check("t5_ready", 32'(cmd_ready), 32'(1));

        // self move 4 -> 4
        cmd_valid = 1'b1; cmd_src = 5'd4; cmd_dst = 5'd4;
        cyc(); cmd_valid = 1'b0;
        cyc();
        cyc();
        check("t6_oe_latch", 32'(oe), 32'h10);
        check("t6_ie_latch", 32'(ie), 32'h10);
        cyc();
        check("t6_done", 32'(done), 32'(1));
        check("t6_reg4", regs[4], 32'h4444_4444);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
